// File: rtl/bfsm_stim_tx_if.sv
// Handshake, serial link and result bundle between a host/bFSM environment
// and the bfsm_stim_tx block.
interface bfsm_stim_tx_if #(
  parameter int unsigned WIDTH = 8
);
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] data_in;
  logic             seq_rst;
  logic             x_out;
  logic             y_in;
  logic [WIDTH-1:0] y_word;
  logic             done;
  logic             mismatch;

  modport master (
    output load_valid, data_in, y_in,
    input  load_ready, seq_rst, x_out, y_word, done, mismatch
  );

  modport slave (
    input  load_valid, data_in, y_in,
    output load_ready, seq_rst, x_out, y_word, done, mismatch
  );
endinterface

// File: rtl/bfsm_stim_tx.sv
// Serial stimulus transmitter for the 5-state Mealy bFSM: resets it, shifts a
// frame onto X MSB-first, captures Y and checks it against a golden model.
module bfsm_stim_tx #(
  parameter int unsigned WIDTH = 8
) (
  input logic           CLK,
  input logic           RST,
  bfsm_stim_tx_if.slave bus
);
  localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StPulse, StShift, StFin} state_e;
  typedef enum logic [2:0] {MdA, MdB, MdC, MdD, MdE} model_e;

  state_e           state_q, state_d;
  model_e           model_q, model_d, model_nxt;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] yw_q, yw_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             mm_q, mm_d;
  logic             seq_rst_q, seq_rst_d;
  logic             x_q, x_d;
  logic             done_q, done_d;
  logic             exp_y;

  // Golden model transition on the bit currently driven onto X.
  always_comb begin
    model_nxt = MdA;
    case (model_q)
      MdA:     model_nxt = x_q ? MdB : MdA;
      MdB:     model_nxt = x_q ? MdD : MdC;
      MdC:     model_nxt = x_q ? MdE : MdC;
      MdD:     model_nxt = x_q ? MdC : MdA;
      MdE:     model_nxt = x_q ? MdB : MdD;
      default: model_nxt = MdA;
    endcase
  end

  assign exp_y = x_q & (model_q != MdB);

  always_comb begin
    state_d   = state_q;
    model_d   = model_q;
    sh_d      = sh_q;
    yw_d      = yw_q;
    cnt_d     = cnt_q;
    mm_d      = mm_q;
    seq_rst_d = 1'b0;
    x_d       = 1'b0;
    done_d    = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.load_valid) begin
          sh_d      = bus.data_in;
          yw_d      = '0;
          mm_d      = 1'b0;
          seq_rst_d = 1'b1;
          state_d   = StPulse;
        end
      end
      StPulse: begin
        model_d = MdA;
        cnt_d   = '0;
        x_d     = sh_q[WIDTH-1];
        sh_d    = {sh_q[WIDTH-2:0], 1'b0};
        state_d = StShift;
      end
      StShift: begin
        yw_d    = {yw_q[WIDTH-2:0], bus.y_in};
        mm_d    = mm_q | (bus.y_in != exp_y);
        model_d = model_nxt;
        cnt_d   = cnt_q + CntW'(1);
        if (cnt_q == CntW'(WIDTH - 1)) begin
          done_d  = 1'b1;
          state_d = StFin;
        end else begin
          x_d  = sh_q[WIDTH-1];
          sh_d = {sh_q[WIDTH-2:0], 1'b0};
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= StIdle;
      model_q   <= MdA;
      sh_q      <= '0;
      yw_q      <= '0;
      cnt_q     <= '0;
      mm_q      <= 1'b0;
      seq_rst_q <= 1'b0;
      x_q       <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      model_q   <= model_d;
      sh_q      <= sh_d;
      yw_q      <= yw_d;
      cnt_q     <= cnt_d;
      mm_q      <= mm_d;
      seq_rst_q <= seq_rst_d;
      x_q       <= x_d;
      done_q    <= done_d;
    end
  end

  assign bus.load_ready = (state_q == StIdle);
  assign bus.seq_rst    = seq_rst_q;
  assign bus.x_out      = x_q;
  assign bus.y_word     = yw_q;
  assign bus.done       = done_q;
  assign bus.mismatch   = mm_q;
endmodule

// File: tb/tb_bfsm_stim_tx.sv
// Directed bench for bfsm_stim_tx with an attached behavioural bFSM and a
// scoreboard of expected frame results.
module tb_bfsm_stim_tx;
  logic CLK;
  logic RST;
  logic y_tie0;
  logic [2:0] bst;
  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [7:0] d;
    logic [7:0] y;
    logic       m;
  } exp_t;
  exp_t sb[$];

  bfsm_stim_tx_if #(.WIDTH(8)) bus ();

  bfsm_stim_tx #(.WIDTH(8)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Downstream bFSM: A=0 B=1 C=2 D=3 E=4, Mealy Y = X & (state != B).
  always @(posedge CLK or posedge RST) begin
    if (RST) bst <= 3'd0;
    else if (bus.seq_rst) bst <= 3'd0;
    else begin
      case (bst)
        3'd0:    bst <= bus.x_out ? 3'd1 : 3'd0;
        3'd1:    bst <= bus.x_out ? 3'd3 : 3'd2;
        3'd2:    bst <= bus.x_out ? 3'd4 : 3'd2;
        3'd3:    bst <= bus.x_out ? 3'd2 : 3'd0;
        3'd4:    bst <= bus.x_out ? 3'd1 : 3'd3;
        default: bst <= 3'd0;
      endcase
    end
  end

  assign bus.y_in = y_tie0 ? 1'b0 : (bus.x_out & (bst != 3'd1));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic frame(input logic [7:0] d, input logic [7:0] ey, input logic em,
                       input logic keep_valid, input logic [7:0] next_d, input logic noise);
    exp_t e;
    int   n;
    bus.load_valid = 1'b1;
    bus.data_in    = d;
    sb.push_back('{d: d, y: ey, m: em});
    n = 0;
    while (!bus.load_ready && n < 20) begin
      @(negedge CLK);
      n++;
    end
    chk("ready_before_load", {31'd0, bus.load_ready}, 32'd1);
    @(posedge CLK);
    #1;
    bus.load_valid = keep_valid;
    bus.data_in    = next_d;
    @(negedge CLK);
    chk("pulse_seq_rst", {31'd0, bus.seq_rst}, 32'd1);
    chk("pulse_x", {31'd0, bus.x_out}, 32'd0);
    chk("pulse_ready", {31'd0, bus.load_ready}, 32'd0);
    for (int k = 0; k < 8; k++) begin
      if (noise) bus.load_valid = (k == 2 || k == 5);
      @(negedge CLK);
      chk($sformatf("shift%0d_x", k), {31'd0, bus.x_out}, {31'd0, d[7-k]});
      chk($sformatf("shift%0d_seq_rst", k), {31'd0, bus.seq_rst}, 32'd0);
      chk($sformatf("shift%0d_ready", k), {31'd0, bus.load_ready}, 32'd0);
      chk($sformatf("shift%0d_done", k), {31'd0, bus.done}, 32'd0);
    end
    if (noise) bus.load_valid = keep_valid;
    @(negedge CLK);
    chk("fin_done", {31'd0, bus.done}, 32'd1);
    chk("fin_ready", {31'd0, bus.load_ready}, 32'd0);
    chk("fin_x", {31'd0, bus.x_out}, 32'd0);
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk($sformatf("y_word_%0h", e.d), {24'd0, bus.y_word}, {24'd0, e.y});
      chk($sformatf("mismatch_%0h", e.d), {31'd0, bus.mismatch}, {31'd0, e.m});
    end
    @(negedge CLK);
    chk("after_done_low", {31'd0, bus.done}, 32'd0);
    chk("after_ready", {31'd0, bus.load_ready}, 32'd1);
    chk("after_hold_y", {24'd0, bus.y_word}, {24'd0, ey});
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, {31'd0, bus.load_ready}, 32'd1);
    chk({tag, "_seq_rst"}, {31'd0, bus.seq_rst}, 32'd0);
    chk({tag, "_x"}, {31'd0, bus.x_out}, 32'd0);
    chk({tag, "_y_word"}, {24'd0, bus.y_word}, 32'd0);
    chk({tag, "_done"}, {31'd0, bus.done}, 32'd0);
    chk({tag, "_mismatch"}, {31'd0, bus.mismatch}, 32'd0);
  endtask

  initial begin
    int seen_done;
    RST            = 1'b1;
    y_tie0         = 1'b0;
    bus.load_valid = 1'b0;
    bus.data_in    = 8'h00;
    #12;
    chk_reset_vals("reset");
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);

    // 1, 2: live bFSM
    frame(8'hAA, 8'hAA, 1'b0, 1'b0, 8'h00, 1'b0);
    frame(8'hF0, 8'hB0, 1'b0, 1'b0, 8'h00, 1'b0);

    // 3: Y stuck low
    y_tie0 = 1'b1;
    frame(8'hAA, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
    y_tie0 = 1'b0;

    // 4: back-to-back with valid held high; DATA_IN changes mid-frame
    frame(8'hAA, 8'hAA, 1'b0, 1'b1, 8'hF0, 1'b0);
    frame(8'hF0, 8'hB0, 1'b0, 1'b0, 8'h00, 1'b0);

    // 5: reset during SHIFT cycle 4
    bus.data_in    = 8'hF0;
    bus.load_valid = 1'b1;
    @(posedge CLK);
    #1;
    bus.load_valid = 1'b0;
    repeat (5) @(negedge CLK);
    chk("partial_y_word", {24'd0, bus.y_word}, 32'h05);
    @(negedge CLK);
    chk("shift4_x_pre_reset", {31'd0, bus.x_out}, 32'd0);
    #1;
    RST = 1'b1;
    #1;
    chk_reset_vals("async_reset");
    @(negedge CLK);
    RST = 1'b0;
    seen_done = 0;
    repeat (12) begin
      @(negedge CLK);
      if (bus.done) seen_done++;
    end
    chk("no_done_after_reset", seen_done, 32'd0);
    frame(8'hF0, 8'hB0, 1'b0, 1'b0, 8'h00, 1'b0);

    // 6: all-zero frame with valid noise during SHIFT
    frame(8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
    repeat (3) @(negedge CLK);
    chk("idle_after_noise_ready", {31'd0, bus.load_ready}, 32'd1);
    chk("scoreboard_drained", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end
endmodule
